// File: rtl/xoodoo_perm_if.sv
// Purpose: valid/ready word streams between a Xoodyak controller and the
//          iterative Xoodoo permutation engine.
// Signals: nr (round count, sampled with word 0), din/din_valid/din_ready
//          (state words in), dout/dout_valid/dout_ready (state words out),
//          busy (engine is permuting or unloading).
// master: the controller side; slave: the permutation engine.
interface xoodoo_perm_if;
  logic [3:0]  nr;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;

  modport master (
    output nr, din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, busy
  );

  modport slave (
    input  nr, din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, busy
  );
endinterface

// File: rtl/xoodoo_perm_engine.sv
// Purpose: iterative Xoodoo[n] permutation. Loads a 384-bit state as 12 words,
//          runs one round per clock for the latched round count, then returns
//          the permuted state in the same word order.
// Ports:   clk, rst_n (async, active-low), bus (xoodoo_perm_if.slave).
//          Word i of the stream is state[32*i +: 32]; plane y = i/4, lane x = i%4.
module xoodoo_perm_engine #(
  parameter int unsigned MAX_ROUNDS = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  xoodoo_perm_if.slave  bus
);

  localparam int unsigned W  = 32;
  localparam int unsigned NW = 12;
  localparam int unsigned SW = W * NW;
  localparam logic [3:0]  MAX_NR    = 4'(MAX_ROUNDS);
  localparam logic [3:0]  LAST_WORD = 4'(NW - 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_RUN    = 2'd1,
    S_UNLOAD = 2'd2
  } state_t;

  state_t        st_q, st_d;
  logic [SW-1:0] state_q, state_d;
  logic [3:0]    word_q, word_d;
  logic [3:0]    round_q, round_d;
  logic [3:0]    nr_l_q, nr_l_d;
  logic [3:0]    nr_clamp;
  logic [3:0]    rc_idx;
  logic [8:0]    word_base;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int unsigned n);
    rotl = (x << n) | (x >> (W - n));
  endfunction

  // Round-constant table; the last n entries serve Xoodoo[n].
  function automatic logic [W-1:0] rc_lookup(input logic [3:0] idx);
    case (idx)
      4'd0:    rc_lookup = 32'h0000_0058;
      4'd1:    rc_lookup = 32'h0000_0038;
      4'd2:    rc_lookup = 32'h0000_03C0;
      4'd3:    rc_lookup = 32'h0000_00D0;
      4'd4:    rc_lookup = 32'h0000_0120;
      4'd5:    rc_lookup = 32'h0000_0014;
      4'd6:    rc_lookup = 32'h0000_0060;
      4'd7:    rc_lookup = 32'h0000_002C;
      4'd8:    rc_lookup = 32'h0000_0380;
      4'd9:    rc_lookup = 32'h0000_00F0;
      4'd10:   rc_lookup = 32'h0000_01A0;
      4'd11:   rc_lookup = 32'h0000_0012;
      default: rc_lookup = '0;
    endcase
  endfunction

  // One Xoodoo round: theta, rho-west, iota, chi, rho-east.
  function automatic logic [SW-1:0] xoodoo_round(input logic [SW-1:0] s,
                                                 input logic [W-1:0]  rc);
    logic [W-1:0] a0 [4];
    logic [W-1:0] a1 [4];
    logic [W-1:0] a2 [4];
    logic [W-1:0] p  [4];
    logic [W-1:0] e  [4];
    logic [W-1:0] w1 [4];
    logic [W-1:0] w2 [4];
    logic [W-1:0] c0 [4];
    logic [W-1:0] c1 [4];
    logic [W-1:0] c2 [4];
    logic [SW-1:0] r;
    for (int x = 0; x < 4; x++) begin
      a0[x] = s[W*x +: W];
      a1[x] = s[W*(4+x) +: W];
      a2[x] = s[W*(8+x) +: W];
      p[x]  = a0[x] ^ a1[x] ^ a2[x];
    end
    // Column-parity effect comes from the neighbouring lane x-1.
    for (int x = 0; x < 4; x++) begin
      e[x]  = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
      a0[x] = a0[x] ^ e[x];
      a1[x] = a1[x] ^ e[x];
      a2[x] = a2[x] ^ e[x];
    end
    for (int x = 0; x < 4; x++) begin
      w1[x] = a1[(x+3)%4];
      w2[x] = rotl(a2[x], 11);
    end
    a0[0] = a0[0] ^ rc;
    for (int x = 0; x < 4; x++) begin
      c0[x] = a0[x] ^ (~w1[x] & w2[x]);
      c1[x] = w1[x] ^ (~w2[x] & a0[x]);
      c2[x] = w2[x] ^ (~a0[x] & w1[x]);
    end
    for (int x = 0; x < 4; x++) begin
      r[W*x +: W]     = c0[x];
      r[W*(4+x) +: W] = rotl(c1[x], 1);
      r[W*(8+x) +: W] = rotl(c2[(x+2)%4], 8);
    end
    return r;
  endfunction

  assign nr_clamp  = (bus.nr > MAX_NR) ? MAX_NR : bus.nr;
  assign rc_idx    = MAX_NR - nr_l_q + round_q;
  assign word_base = {word_q, 5'd0};

  // Next-state, datapath and counter updates.
  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    word_d  = word_q;
    round_d = round_q;
    nr_l_d  = nr_l_q;
    case (st_q)
      S_LOAD: begin
        if (bus.din_valid) begin
          state_d[word_base +: W] = bus.din;
          if (word_q == 4'd0) nr_l_d = nr_clamp;
          if (word_q == LAST_WORD) begin
            word_d = '0;
            // Word 11 is never word 0, so nr_l_q is already latched here.
            st_d   = (nr_l_q != 4'd0) ? S_RUN : S_UNLOAD;
          end else begin
            word_d = word_q + 4'd1;
          end
        end
      end
      S_RUN: begin
        state_d = xoodoo_round(state_q, rc_lookup(rc_idx));
        if (round_q == nr_l_q - 4'd1) begin
          round_d = '0;
          st_d    = S_UNLOAD;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      S_UNLOAD: begin
        if (bus.dout_ready) begin
          if (word_q == LAST_WORD) begin
            word_d = '0;
            st_d   = S_LOAD;
          end else begin
            word_d = word_q + 4'd1;
          end
        end
      end
      default: st_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_LOAD;
      state_q <= '0;
      word_q  <= '0;
      round_q <= '0;
      nr_l_q  <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      word_q  <= word_d;
      round_q <= round_d;
      nr_l_q  <= nr_l_d;
    end
  end

  // Stream flags decode straight from the state register.
  assign bus.din_ready  = (st_q == S_LOAD);
  assign bus.dout_valid = (st_q == S_UNLOAD);
  assign bus.busy       = (st_q != S_LOAD);
  assign bus.dout       = (st_q == S_UNLOAD) ? state_q[word_base +: W] : '0;

endmodule

// File: tb/tb_xoodoo_perm_engine.sv
// Purpose: self-checking bench for xoodoo_perm_engine against a lane-array
//          Xoodoo reference model.
module tb_xoodoo_perm_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  xoodoo_perm_if bus ();

  xoodoo_perm_engine #(.MAX_ROUNDS(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] rc_tab [12] = '{32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
                               32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};

  typedef struct {
    logic [383:0] st;
    logic [3:0]   nr;
    int           pv;
    int           pr;
    logic [383:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs [8];

  task automatic chk_big(input string name, input logic [383:0] act, input logic [383:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    logic [63:0] d;
    d = {v, v} << n;
    return d[63:32];
  endfunction

  // Reference round on a plane/lane array A[y][x].
  function automatic logic [383:0] ref_round(input logic [383:0] s, input logic [31:0] rc);
    logic [31:0] A [3][4];
    logic [31:0] B [3][4];
    logic [31:0] P [4];
    logic [383:0] r;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) A[y][x] = s[32*(4*y+x) +: 32];
    for (int x = 0; x < 4; x++) P[x] = A[0][x] ^ A[1][x] ^ A[2][x];
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++)
        A[y][x] = A[y][x] ^ rol(P[(x+3)%4], 5) ^ rol(P[(x+3)%4], 14);
    B = A;
    for (int x = 0; x < 4; x++) begin
      A[1][x] = B[1][(x+3)%4];
      A[2][x] = rol(B[2][x], 11);
    end
    A[0][0] = A[0][0] ^ rc;
    B = A;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++)
        A[y][x] = B[y][x] ^ (~B[(y+1)%3][x] & B[(y+2)%3][x]);
    B = A;
    for (int x = 0; x < 4; x++) begin
      A[1][x] = rol(B[1][x], 1);
      A[2][x] = rol(B[2][(x+2)%4], 8);
    end
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) r[32*(4*y+x) +: 32] = A[y][x];
    return r;
  endfunction

  function automatic logic [383:0] ref_perm(input logic [383:0] s, input int nr);
    int n;
    n = (nr > 12) ? 12 : nr;
    for (int i = 12 - n; i < 12; i++) s = ref_round(s, rc_tab[i]);
    return s;
  endfunction

  function automatic logic [383:0] rand_state();
    logic [383:0] s;
    for (int i = 0; i < 12; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed 12 words at pv% valid duty; nr is garbage after word 0.
  task automatic load_block(input logic [383:0] st, input logic [3:0] nr, input int pv,
                            output int bad);
    int i;
    int budget;
    i = 0;
    budget = 0;
    bad = 0;
    while (i < 12 && budget < 2000) begin
      bus.din        = st[32*i +: 32];
      bus.nr         = (i == 0) ? nr : 4'($urandom);
      bus.din_valid  = ($urandom_range(99) < pv);
      bus.dout_ready = 1'($urandom_range(1));
      if (!bus.din_ready || bus.dout_valid || bus.busy) bad++;
      if (bus.din_valid && bus.din_ready) i++;
      step();
      budget++;
    end
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b0;
    chk_int("load_words", i, 12);
  endtask

  // Wait for the result (poking junk into din), then drain at pr% ready duty.
  task automatic unload_block(input int pr, output logic [383:0] got, output int lat,
                              output int bad);
    int j;
    int budget;
    j = 0;
    budget = 0;
    got = '0;
    lat = 1;
    bad = 0;
    while (!bus.dout_valid && budget < 200) begin
      bus.din_valid  = 1'($urandom_range(1));
      bus.din        = $urandom;
      bus.dout_ready = 1'($urandom_range(1));
      if (bus.din_ready || !bus.busy) bad++;
      step();
      lat++;
      budget++;
    end
    while (j < 12 && budget < 2000) begin
      bus.din_valid  = 1'($urandom_range(1));
      bus.din        = $urandom;
      bus.dout_ready = ($urandom_range(99) < pr);
      if (bus.din_ready || !bus.busy || !bus.dout_valid) bad++;
      if (bus.dout_ready && bus.dout_valid) begin
        got[32*j +: 32] = bus.dout;
        j++;
      end
      step();
      budget++;
    end
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b0;
    chk_int("unload_words", j, 12);
  endtask

  task automatic chk_idle(input string name);
    chk_int(name, int'({bus.din_ready, bus.busy, bus.dout_valid}), 4);
  endtask

  task automatic chk_reset_vals(input string name);
    chk_int(name, int'({bus.din_ready, bus.busy, bus.dout_valid}), 4);
    chk_int({name, "_dout"}, int'(bus.dout), 0);
  endtask

  // Full block with result and protocol checks.
  task automatic run_block(input string name, input logic [383:0] st, input logic [3:0] nr,
                           input int pv, input int pr, input logic [383:0] exp,
                           input int exp_lat);
    int bad_l;
    int bad_u;
    int lat;
    logic [383:0] got;
    load_block(st, nr, pv, bad_l);
    unload_block(pr, got, lat, bad_u);
    chk_big({name, "_data"}, got, exp);
    chk_int({name, "_lat"}, lat, exp_lat);
    chk_int({name, "_load_flags"}, bad_l, 0);
    chk_int({name, "_busy_flags"}, bad_u, 0);
    chk_idle({name, "_idle"});
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [383:0] s;
    logic [383:0] got;
    int bad;
    int lat;
    int seen;
    int n_ok;
    int fb;

    bus.nr = '0;
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.dout_ready = 1'b0;

    #2 rst_n = 1'b0;
    #1 chk_reset_vals("reset");
    #9 rst_n = 1'b1;
    step();
    chk_reset_vals("after_reset");

    // Vector table
    vecs[0].st = '0;
    vecs[0].nr = 4'd12; vecs[0].pv = 100; vecs[0].pr = 100;
    for (int i = 0; i < 12; i++) s[32*i +: 32] = 32'(i);
    vecs[1].st = s;
    vecs[1].nr = 4'd0;  vecs[1].pv = 100; vecs[1].pr = 100;
    vecs[2].st = rand_state();
    vecs[2].nr = 4'd6;  vecs[2].pv = 100; vecs[2].pr = 100;
    vecs[3].st = rand_state();
    vecs[3].nr = 4'd15; vecs[3].pv = 100; vecs[3].pr = 100;
    vecs[4].st = vecs[3].st;
    vecs[4].nr = 4'd12; vecs[4].pv = 100; vecs[4].pr = 100;
    vecs[5].st = rand_state();
    vecs[5].nr = 4'd13; vecs[5].pv = 50;  vecs[5].pr = 50;
    vecs[6].st = rand_state();
    vecs[6].nr = 4'd1;  vecs[6].pv = 50;  vecs[6].pr = 50;
    vecs[7].st = rand_state();
    vecs[7].nr = 4'd0;  vecs[7].pv = 30;  vecs[7].pr = 30;
    for (int v = 0; v < 8; v++) begin
      vecs[v].exp = ref_perm(vecs[v].st, int'(vecs[v].nr));
      vecs[v].lat = ((vecs[v].nr > 4'd12) ? 12 : int'(vecs[v].nr)) + 1;
    end
    // Pass-through must reproduce the counting pattern word for word.
    vecs[1].exp = s;

    for (int v = 0; v < 8; v++)
      run_block($sformatf("vec%0d", v), vecs[v].st, vecs[v].nr, vecs[v].pv, vecs[v].pr,
                vecs[v].exp, vecs[v].lat);

    // Back-to-back random blocks, nr = 12, ~50% duty on both streams.
    n_ok = 0;
    fb = fails;
    for (int b = 0; b < 100; b++) begin
      s = rand_state();
      run_block($sformatf("stress%0d", b), s, 4'd12, 50, 50, ref_perm(s, 12), 13);
    end
    chk_int("stress_no_new_fails", fails - fb, 0);

    // Reset during RUN, after 5 rounds.
    s = rand_state();
    load_block(s, 4'd12, 100, bad);
    for (int k = 0; k < 5; k++) step();
    chk_int("pre_reset_run_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1 chk_reset_vals("reset_mid_run");
    #1 rst_n = 1'b1;
    step();
    chk_idle("idle_after_run_reset");
    s = rand_state();
    run_block("post_run_reset", s, 4'd12, 100, 100, ref_perm(s, 12), 13);

    // Reset during UNLOAD after 7 words delivered.
    s = rand_state();
    load_block(s, 4'd9, 100, bad);
    seen = 0;
    while (!bus.dout_valid && seen < 50) begin
      step();
      seen++;
    end
    got = '0;
    for (int k = 0; k < 7; k++) begin
      bus.dout_ready = 1'b1;
      got[32*k +: 32] = bus.dout;
      step();
    end
    bus.dout_ready = 1'b0;
    s = ref_perm(s, 9);
    chk_big("partial_unload", got[223:0], s[223:0]);
    chk_int("pre_reset_unload_valid", int'(bus.dout_valid), 1);
    rst_n = 1'b0;
    #1 chk_reset_vals("reset_mid_unload");
    #1 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      bus.dout_ready = 1'b1;
      step();
      if (bus.dout_valid) seen++;
    end
    bus.dout_ready = 1'b0;
    chk_int("no_residue_output", seen, 0);
    s = rand_state();
    run_block("post_unload_reset", s, 4'd12, 100, 100, ref_perm(s, 12), 13);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
